// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi button front-end.
//   COUNT_W / COUNT_MAX : width and saturation value of the hold-time counters
//   hold_state_t        : hold FSM encoding (IDLE, HELD, SAT)
//   SALUD..TEST         : bit index of each button in the internal button vectors
package tamagotchi_pkg;

    localparam int COUNT_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        SAT  = 2'd2
    } hold_state_t;

    localparam int SALUD     = 0;
    localparam int ENERGIA   = 1;
    localparam int HAMBRE    = 2;
    localparam int DIVERSION = 3;
    localparam int RESET     = 4;
    localparam int TEST      = 5;
    localparam int NUM_BTN   = 6;

endpackage

// File: rtl/btn_debounce.sv
// Single pushbutton conditioner: polarity fix, 2-flop synchroniser,
// counter debounce and registered rising-edge pulse.
//   clk, rst_n : clock, async active-low reset
//   raw        : unsynchronised pin
//   level      : debounced level, pressed = 1
//   rise       : one-cycle pulse the cycle after level rises
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             pressed;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_d;

    // Polarity is fixed before the synchroniser so everything after is pressed=1.
    assign pressed = raw ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pressed};
            level_d <= level;
            rise    <= level & ~level_d;
            // Any sample agreeing with the stable level restarts the count.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tamagotchi_button_ctrl.sv
// Button front-end for tamagotchi_fsm. Six raw pushbuttons are debounced;
// the four action buttons yield one-cycle press pulses, reset/test yield
// debounced levels plus saturating whole-second hold counters.
//   clk, rst_n               : clock, async active-low reset
//   raw_*                    : unsynchronised board pins
//   btn_salud..btn_diversion : press pulses
//   btn_reset, btn_test      : debounced pressed levels
//   count_reset, count_test  : seconds held, saturating at 7
module tamagotchi_button_ctrl
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_salud,
    input  logic               raw_energia,
    input  logic               raw_hambre,
    input  logic               raw_diversion,
    input  logic               raw_reset,
    input  logic               raw_test,
    output logic               btn_salud,
    output logic               btn_energia,
    output logic               btn_hambre,
    output logic               btn_diversion,
    output logic               btn_reset,
    output logic               btn_test,
    output logic [COUNT_W-1:0] count_reset,
    output logic [COUNT_W-1:0] count_test
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam logic [TICK_W-1:0]  TICK_LAST     = TICK_W'(TICK_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_PRE_SAT = COUNT_MAX - COUNT_W'(1);

    if (TICK_CYCLES < 2) begin : g_bad_param
        $error("tamagotchi_button_ctrl: TICK_CYCLES must be >= 2");
    end

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] rise_vec;
    logic [1:0][COUNT_W-1:0] hold_cnt;

    assign raw_vec = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW != 0)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_vec[b]),
            .level(level_vec[b]),
            .rise (rise_vec[b])
        );
    end

    // Hold FSMs for reset (h=0) and test (h=1).
    for (genvar h = 0; h < 2; h++) begin : g_hold
        hold_state_t        state_q;
        logic [TICK_W-1:0]  tick_q;
        logic [COUNT_W-1:0] cnt_q;
        logic               lvl;

        assign lvl         = level_vec[RESET + h];
        assign hold_cnt[h] = cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                tick_q  <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q  <= '0;
                        tick_q <= '0;
                        // The level rose one edge ago; starting tick at 1 counts
                        // that cycle so count=1 lands TICK_CYCLES after the rise.
                        if (lvl) begin
                            state_q <= HELD;
                            tick_q  <= TICK_W'(1);
                        end
                    end
                    HELD: begin
                        if (!lvl) begin
                            state_q <= IDLE;
                            tick_q  <= '0;
                            cnt_q   <= '0;
                        end else if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == COUNT_PRE_SAT) state_q <= SAT;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    SAT: begin
                        if (!lvl) begin
                            state_q <= IDLE;
                            tick_q  <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_salud     = rise_vec[SALUD];
    assign btn_energia   = rise_vec[ENERGIA];
    assign btn_hambre    = rise_vec[HAMBRE];
    assign btn_diversion = rise_vec[DIVERSION];
    assign btn_reset     = level_vec[RESET];
    assign btn_test      = level_vec[TEST];
    assign count_reset   = hold_cnt[0];
    assign count_test    = hold_cnt[1];

    // Action buttons only expose pulses, reset/test only levels.
    logic unused_sigs;
    assign unused_sigs = ^{level_vec[DIVERSION:SALUD], rise_vec[TEST:RESET]};

endmodule

// File: tb/tb_tamagotchi_button_ctrl.sv
module tb_tamagotchi_button_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test;
    logic btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
    logic [2:0] count_reset, count_test;

    tamagotchi_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (20),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_salud    (raw_salud),
        .raw_energia  (raw_energia),
        .raw_hambre   (raw_hambre),
        .raw_diversion(raw_diversion),
        .raw_reset    (raw_reset),
        .raw_test     (raw_test),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    always #5 clk = ~clk;

    // press bits: 0 salud, 1 energia, 2 hambre, 3 diversion, 4 reset, 5 test
    // expected outputs are the values just after edge cyc
    typedef struct {
        int         cyc;
        logic [5:0] press;
        logic [3:0] pulse;
        logic       lr;
        logic       lt;
        logic [2:0] cr;
        logic [2:0] ct;
    } vec_t;

    vec_t vecs[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   npulse[4] = '{0, 0, 0, 0};
    logic [3:0] pulses;

    assign pulses = {btn_diversion, btn_hambre, btn_energia, btn_salud};

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) if (pulses[i]) npulse[i]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] p);
        {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud} = ~p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic at(input int c);
        goto(c);
        @(negedge clk);
    endtask

    initial begin
        // clean press on salud
        vecs.push_back('{  0, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 10, 6'b000001, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 16, 6'b000001, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 17, 6'b000001, 4'b0001, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 18, 6'b000001, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 40, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 47, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        // bouncing hambre, final press at 72
        vecs.push_back('{ 60, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 62, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 64, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 66, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 68, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 70, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 72, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 78, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 79, 6'b000100, 4'b0100, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{ 80, 6'b000100, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{100, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{107, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        // energia + diversion together
        vecs.push_back('{120, 6'b001010, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{126, 6'b001010, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{127, 6'b001010, 4'b1010, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{128, 6'b001010, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{130, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        // short test hold
        vecs.push_back('{150, 6'b100000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{155, 6'b100000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{156, 6'b100000, 4'b0000, 0, 1, 3'd0, 3'd0});
        vecs.push_back('{165, 6'b000000, 4'b0000, 0, 1, 3'd0, 3'd0});
        vecs.push_back('{170, 6'b000000, 4'b0000, 0, 1, 3'd0, 3'd0});
        vecs.push_back('{171, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{173, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        // long reset hold with saturation
        vecs.push_back('{200, 6'b010000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{205, 6'b010000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{206, 6'b010000, 4'b0000, 1, 0, 3'd0, 3'd0});
        vecs.push_back('{225, 6'b010000, 4'b0000, 1, 0, 3'd0, 3'd0});
        vecs.push_back('{226, 6'b010000, 4'b0000, 1, 0, 3'd1, 3'd0});
        vecs.push_back('{246, 6'b010000, 4'b0000, 1, 0, 3'd2, 3'd0});
        vecs.push_back('{345, 6'b010000, 4'b0000, 1, 0, 3'd6, 3'd0});
        vecs.push_back('{346, 6'b010000, 4'b0000, 1, 0, 3'd7, 3'd0});
        vecs.push_back('{380, 6'b010000, 4'b0000, 1, 0, 3'd7, 3'd0});
        vecs.push_back('{400, 6'b000000, 4'b0000, 1, 0, 3'd7, 3'd0});
        vecs.push_back('{405, 6'b000000, 4'b0000, 1, 0, 3'd7, 3'd0});
        vecs.push_back('{407, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{410, 6'b000000, 4'b0000, 0, 0, 3'd0, 3'd0});
        // reset held again, to be interrupted by rst_n
        vecs.push_back('{450, 6'b010000, 4'b0000, 0, 0, 3'd0, 3'd0});
        vecs.push_back('{456, 6'b010000, 4'b0000, 1, 0, 3'd0, 3'd0});
        vecs.push_back('{476, 6'b010000, 4'b0000, 1, 0, 3'd1, 3'd0});
        vecs.push_back('{496, 6'b010000, 4'b0000, 1, 0, 3'd2, 3'd0});
        vecs.push_back('{516, 6'b010000, 4'b0000, 1, 0, 3'd3, 3'd0});
        vecs.push_back('{520, 6'b010000, 4'b0000, 1, 0, 3'd3, 3'd0});

        drive(6'b000000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        foreach (vecs[i]) begin
            goto(vecs[i].cyc);
            drive(vecs[i].press);
            @(negedge clk);
            chk("pulses", pulses, vecs[i].pulse);
            chk("btn_reset", btn_reset, vecs[i].lr);
            chk("btn_test", btn_test, vecs[i].lt);
            chk("count_reset", count_reset, vecs[i].cr);
            chk("count_test", count_test, vecs[i].ct);
        end

        // asynchronous reset mid-hold, button kept pressed throughout
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {pulses, btn_reset, btn_test, count_reset, count_test}, 0);
        at(521);
        chk("in_reset_outputs",
            {pulses, btn_reset, btn_test, count_reset, count_test}, 0);
        goto(523);
        rst_n = 1'b1;
        at(528);
        chk("post_rst_btn_reset_early", btn_reset, 0);
        at(529);
        chk("post_rst_btn_reset", btn_reset, 1);
        chk("post_rst_count_start", count_reset, 0);
        at(548);
        chk("post_rst_count_before_tick", count_reset, 0);
        at(549);
        chk("post_rst_count_first", count_reset, 1);

        // each action button pressed once overall: exactly one pulse each
        chk("npulse_salud", npulse[0], 1);
        chk("npulse_energia", npulse[1], 1);
        chk("npulse_hambre", npulse[2], 1);
        chk("npulse_diversion", npulse[3], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
